// File: rtl/noc_arb_pkg.sv
// ============================================================================
// Module  : noc_arb_pkg
// Purpose : Shared word type, default width and round-robin search helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_arb_pkg;

  localparam int NOC_DATA_W  = 64;
  localparam int NOC_MAX_CPU = 16;

  typedef logic [NOC_DATA_W-1:0] noc_word_t;

  // Returns {found, index}: first set bit of vld_mask scanning from ptr, modulo n.
  function automatic logic [4:0] rr_next(input logic [3:0]  ptr,
                                         input logic [15:0] vld_mask,
                                         input int          n);
    logic [4:0] res;
    int         idx;
    res = '0;
    for (int k = 0; k < NOC_MAX_CPU; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !res[4] && vld_mask[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/noc_rr_pick.sv
// ============================================================================
// Module  : noc_rr_pick
// Purpose : Combinational rotate-and-find-first over CPU_NB request bits.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_rr_pick
  import noc_arb_pkg::*;
#(
  parameter int CPU_NB = 4,
  parameter int SRC_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
  input  logic [SRC_W-1:0]  rr_ptr,
  input  logic [CPU_NB-1:0] vld,
  output logic [SRC_W-1:0]  winner,
  output logic              found
);

  logic [15:0] mask;
  logic [3:0]  ptr;
  logic [4:0]  res;

  assign mask   = 16'(vld);
  assign ptr    = 4'(rr_ptr);
  assign res    = rr_next(ptr, mask, CPU_NB);
  assign winner = SRC_W'(res[3:0]);
  assign found  = res[4];

endmodule

`default_nettype wire

// File: rtl/noc_rr_arbiter.sv
// ============================================================================
// Module  : noc_rr_arbiter
// Purpose : Round-robin merge of CPU_NB valid/ready streams into one registered
//           NOC stream. Per-source word counters exist when NOC_ARB_STATS_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int CPU_NB = 4,
  parameter int DATA_W = NOC_DATA_W,
  parameter int SRC_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CPU_NB-1:0]              data_vld,
  output logic [CPU_NB-1:0]              data_rdy,
  input  logic [CPU_NB-1:0][DATA_W-1:0]  data,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [DATA_W-1:0]              out_data,
  output logic [SRC_W-1:0]               out_src
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [CPU_NB-1:0][31:0]        txn_cnt
`endif
);

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] winner;
  logic             found;
  logic             can_load;
  logic             load;

  noc_rr_pick #(
    .CPU_NB (CPU_NB),
    .SRC_W  (SRC_W)
  ) u_pick (
    .rr_ptr (rr_ptr),
    .vld    (data_vld),
    .winner (winner),
    .found  (found)
  );

  assign can_load = !out_vld || out_rdy;
  // Held off during reset so no requester sees a handshake the register will drop.
  assign load     = !rst && can_load && found;

  generate
    for (genvar i = 0; i < CPU_NB; i++) begin : g_rdy
      assign data_rdy[i] = load && (winner == SRC_W'(i));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_data <= data[winner];
      out_src  <= winner;
      rr_ptr   <= (winner == SRC_W'(CPU_NB - 1)) ? '0 : winner + 1'b1;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

`ifdef NOC_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt <= '0;
    end else if (out_vld && out_rdy) begin
      txn_cnt[out_src] <= txn_cnt[out_src] + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_rr_arbiter.sv
// ============================================================================
// Module  : tb_noc_rr_arbiter
// Purpose : Directed and random self-checking bench for noc_rr_arbiter (CPU_NB=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_noc_rr_arbiter;
  import noc_arb_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         vld;
  logic [N-1:0]         rdy;
  noc_word_t [N-1:0]    din;
  logic                 ovld;
  logic                 ordy;
  noc_word_t            odata;
  logic [1:0]           osrc;
`ifdef NOC_ARB_STATS_EN
  logic [N-1:0][31:0]   cnt;
`endif

  always #5 clk = ~clk;

  noc_rr_arbiter #(.CPU_NB(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_vld (vld),
    .data_rdy (rdy),
    .data     (din),
    .out_vld  (ovld),
    .out_rdy  (ordy),
    .out_data (odata),
    .out_src  (osrc)
`ifdef NOC_ARB_STATS_EN
    ,
    .txn_cnt  (cnt)
`endif
  );

  typedef struct packed {
    logic [1:0] src;
    noc_word_t  data;
  } ent_t;

  ent_t       sb[$];
  ent_t       log_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic       m_vld;
  logic [1:0] m_ptr;
  logic       g_grant;
  logic [1:0] g_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first valid requester scanning from the model pointer.
  task automatic pick(output logic f, output logic [1:0] w);
    logic [1:0] idx;
    f = 1'b0;
    w = 2'd0;
    for (int k = 0; k < N; k++) begin
      idx = m_ptr + 2'(k);
      if (!f && vld[idx]) begin
        f = 1'b1;
        w = idx;
      end
    end
  endtask

  // Called just after a negedge with inputs already driven; returns after the next negedge.
  task automatic cycle();
    logic         can;
    logic         f;
    logic [N-1:0] exp_rdy;
    ent_t         e;
    #1;
    can = !m_vld || ordy;
    pick(f, g_w);
    g_grant = !rst && can && f;
    exp_rdy = g_grant ? (4'b0001 << g_w) : 4'b0000;
    chk("data_rdy", 64'(rdy), 64'(exp_rdy));
    chk("out_vld", 64'(ovld), 64'(m_vld));
    if (m_vld) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        chk("out_data", odata, sb[0].data);
        chk("out_src", 64'(osrc), 64'(sb[0].src));
      end
    end
    if (m_vld && ordy && sb.size() > 0) begin
      e = sb.pop_front();
      log_q.push_back(e);
    end
    if (g_grant) begin
      sb.push_back({g_w, din[g_w]});
      m_ptr = (g_w == 2'd3) ? 2'd0 : g_w + 2'd1;
      m_vld = 1'b1;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_vld", 64'(ovld), 64'd0);
    chk("rst_out_data", odata, 64'd0);
    chk("rst_out_src", 64'(osrc), 64'd0);
    chk("rst_data_rdy", 64'(rdy), 64'd0);
    sb.delete();
    m_vld = 1'b0;
    m_ptr = 2'd0;
    @(posedge clk);
    #1;
    chk("rst_hold_rdy", 64'(rdy), 64'd0);
    chk("rst_hold_vld", 64'(ovld), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq[N];
    int cyc;
    logic busy;

    rst   = 1'b0;
    vld   = '0;
    ordy  = 1'b1;
    din   = '0;
    m_vld = 1'b0;
    m_ptr = 2'd0;
    @(negedge clk);

    // Reset with every requester valid
    vld = 4'hF;
    for (int i = 0; i < N; i++) din[i] = 64'h100 + 64'(i);
    do_reset();

    // Rotation with no bubbles
    log_q.delete();
    repeat (9) cycle();
    chk("rot_len", 64'(log_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      chk("rot_src", 64'(log_q[k].src), 64'(k % 4));
      chk("rot_data", log_q[k].data, 64'h100 + 64'(k % 4));
    end

    // Stall holds the word and freezes the pointer
    ordy = 1'b0;
    repeat (5) cycle();
    ordy = 1'b1;
    log_q.delete();
    repeat (3) cycle();
    chk("stall_len", 64'(log_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < log_q.size(); k++)
      chk("stall_src", 64'(log_q[k].src), 64'(k));

    // Sparse requesters across the wrap point
    do_reset();
    vld = 4'b0100;
    log_q.delete();
    cycle();
    vld = 4'b1001;
    repeat (5) cycle();
    vld = 4'b0000;
    cycle();
    chk("sparse_len", 64'(log_q.size()), 64'd6);
    if (log_q.size() >= 5) begin
      chk("sparse_src0", 64'(log_q[0].src), 64'd2);
      chk("sparse_src1", 64'(log_q[1].src), 64'd3);
      chk("sparse_src2", 64'(log_q[2].src), 64'd0);
      chk("sparse_src3", 64'(log_q[3].src), 64'd3);
      chk("sparse_src4", 64'(log_q[4].src), 64'd0);
    end

    // Reset while a word is stalled in the output register
    vld  = 4'b0010;
    ordy = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_vld", 64'(ovld), 64'd1);
    do_reset();
    vld  = 4'b0100;
    ordy = 1'b1;
    log_q.delete();
    cycle();
    cycle();
    chk("post_rst_len", 64'(log_q.size()), 64'd1);
    if (log_q.size() > 0) chk("post_rst_src", 64'(log_q[0].src), 64'd2);

    // Random traffic: 1000 sequenced words per source, random out_rdy
    vld = '0;
    do_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 20000) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = (seq[i] < 1000) && ($urandom_range(0, 3) != 0);
        din[i] = {32'(i), 32'(seq[i])};
      end
      ordy = ($urandom_range(0, 1) == 1);
      cycle();
      if (g_grant) seq[g_w]++;
      busy = 1'b0;
      for (int i = 0; i < N; i++) if (seq[i] < 1000) busy = 1'b1;
      cyc++;
    end
    chk("random_budget", 64'(busy), 64'd0);
    vld  = '0;
    ordy = 1'b1;
    repeat (3) cycle();
    chk("drained_vld", 64'(ovld), 64'd0);
    chk("drained_sb", 64'(sb.size()), 64'd0);
`ifdef NOC_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("txn_cnt", 64'(cnt[i]), 64'd1000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
